alu_arbiter: RTL and testbench

- Round-robin scheduler that shares one multi-cycle alu_top (start/done handshake, 3-bit op, 8-bit operands, 16-bit result) among NUM_REQ requesters.
- Latches the winning request, pulses the ALU start, waits for done (with a watchdog), then returns the result to the granted requester.
- Sits between client blocks and alu_top; it is the only driver of the ALU's start/op/in_a/in_b.

---
 rtl/alu_arbiter.sv | 83 ++++++++
 tb/tb_alu_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin scheduler sharing one multi-cycle ALU among NUM_REQ requesters,
// with a watchdog that aborts an operation whose done never arrives.
module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64,
  localparam int IW = $clog2(NUM_REQ),
  localparam int CW = $clog2(TIMEOUT) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [3*NUM_REQ-1:0] req_op,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]   resp_valid,
  output logic [15:0]          resp_result,
  output logic                 resp_err,
  output logic                 busy,
  output logic [IW-1:0]        grant_id,
  output logic                 alu_start,
  output logic [2:0]           alu_op,
  output logic [7:0]           alu_a,
  output logic [7:0]           alu_b,
  input  logic                 alu_done,
  input  logic [15:0]          alu_result
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [IW-1:0] ptr, win;
  logic [CW-1:0] cnt;
  logic expired;
  // first asserted request at or above the pointer, wrapping around
  function automatic logic [IW-1:0] pick(input logic [NUM_REQ-1:0] r, input logic [IW-1:0] p);
    pick = p;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (r[(int'(p) + i) % NUM_REQ]) pick = IW'((int'(p) + i) % NUM_REQ);
  endfunction
  assign win = pick(req, ptr);
  // the counter holds WAIT cycles already spent, so this is the last allowed one
  assign expired = cnt == CW'(TIMEOUT - 2);
  assign busy = state != IDLE;
  assign alu_start = state == ISSUE;
  assign resp_valid = state == RESP ? NUM_REQ'(1) << grant_id : '0;
  always_comb begin
    state_nx = state == IDLE  ? (|req ? ISSUE : IDLE) :
               state == ISSUE ? WAIT :
               state == WAIT  ? (alu_done || expired ? RESP : WAIT) : IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_id <= '0;
      ptr <= '0;
      cnt <= '0;
      alu_op <= '0;
      alu_a <= '0;
      alu_b <= '0;
      resp_result <= '0;
      resp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          grant_id <= win;
          alu_op <= req_op[3*int'(win) +: 3];
          alu_a <= req_a[8*int'(win) +: 8];
          alu_b <= req_b[8*int'(win) +: 8];
        end
        ISSUE: cnt <= '0;
        WAIT: if (alu_done) begin
          resp_result <= alu_result;
          resp_err <= 1'b0;
        end else if (expired) begin
          resp_result <= '0;
          resp_err <= 1'b1;
        end else cnt <= cnt + CW'(1);
        RESP: ptr <= grant_id == IW'(NUM_REQ - 1) ? '0 : grant_id + IW'(1);
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized round-robin / ALU-handshake checks against a behavioural model.
module tb_alu_arbiter;
  logic clk = 0, reset = 1;
  logic [3:0] req = 0;
  logic [11:0] req_op = 0;
  logic [31:0] req_a = 0, req_b = 0;
  logic [3:0] resp_valid;
  logic [15:0] resp_result, alu_result;
  logic resp_err, busy, alu_start, alu_done;
  logic [1:0] grant_id;
  logic [2:0] alu_op;
  logic [7:0] alu_a, alu_b;
  int errors = 0, checks = 0, ptr_m = 0, alu_delay = 3;
  bit never_done = 0, stray_done = 0;

  alu_arbiter dut (.clk(clk), .reset(reset), .req(req), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_result(resp_result), .resp_err(resp_err), .busy(busy),
    .grant_id(grant_id), .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result));

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int sa, sb, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (op)
      3'd0: r = sa + sb;
      3'd1: r = sa - sb;
      3'd2: r = sa * sb;
      3'd3: r = sb == 0 ? 65535 : sa / sb;
      3'd4: r = int'(a & b);
      3'd5: r = int'(a | b);
      3'd6: r = int'(a ^ b);
      default: r = 0;
    endcase
    return r[15:0];
  endfunction

  function automatic int ref_pick(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++) if (r[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction

  function automatic logic [15:0] ref_of(input int i);
    return ref_alu(req_op[3*i +: 3], req_a[8*i +: 8], req_b[8*i +: 8]);
  endfunction

  // stand-in ALU: done alu_delay cycles after start, result from the operands it was handed
  initial begin
    int left;
    bit pend;
    alu_done = 0; alu_result = 0; pend = 0; left = 0;
    forever begin
      @(posedge clk); #1;
      alu_done = 0; alu_result = 0;
      if (reset || never_done) pend = 0;
      else if (alu_start) begin pend = 1; left = alu_delay; end
      else if (pend) begin
        left--;
        if (left == 0) begin alu_done = 1; alu_result = ref_alu(alu_op, alu_a, alu_b); pend = 0; end
      end
      if (stray_done) begin alu_done = 1; alu_result = 16'hBEEF; end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_op(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    req_op[3*i +: 3] = op; req_a[8*i +: 8] = a; req_b[8*i +: 8] = b;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < 4; i++)
      set_op(i, 3'($urandom_range(0, 6)), 8'($urandom), ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom));
  endtask

  task automatic wait_resp(output int lat, output logic [3:0] rv, output logic [15:0] rr,
                           output logic re, output logic [1:0] gid, output int starts);
    int n, st;
    n = 0; st = -1; lat = -1; rv = 0; rr = 0; re = 0; gid = 0; starts = 0;
    while (n < 300) begin
      tick(); n++;
      if (alu_start) begin starts++; if (st < 0) st = n; end
      if (resp_valid != 0) begin
        lat = st < 0 ? -1 : n - st; rv = resp_valid; rr = resp_result; re = resp_err; gid = grant_id;
        return;
      end
    end
  endtask

  task automatic pulse_reset();
    reset = 1; tick(); reset = 0; ptr_m = 0;
  endtask

  task automatic test_reset();
    reset = 1; tick(); tick();
    checks++; if (resp_valid !== 0 || busy !== 0 || alu_start !== 0) begin errors++; $display("FAIL reset_ctrl: valid=%b busy=%b start=%b expected 0", resp_valid, busy, alu_start); end
    checks++; if (grant_id !== 0 || alu_op !== 0 || alu_a !== 0 || alu_b !== 0) begin errors++; $display("FAIL reset_latch: gid=%0d op=%0d a=%0h b=%0h expected 0", grant_id, alu_op, alu_a, alu_b); end
    checks++; if (resp_result !== 0 || resp_err !== 0) begin errors++; $display("FAIL reset_resp: result=%h err=%b expected 0", resp_result, resp_err); end
    reset = 0; ptr_m = 0;
  endtask

  task automatic test_single();
    set_op(0, 3'd0, 8'd25, 8'd17); alu_delay = 3; req = 4'b0001;
    tick();
    checks++; if (alu_start !== 1 || busy !== 1 || grant_id !== 0) begin errors++; $display("FAIL single_issue: start=%b busy=%b gid=%0d expected 1 1 0", alu_start, busy, grant_id); end
    checks++; if (alu_op !== 0 || alu_a !== 25 || alu_b !== 17) begin errors++; $display("FAIL single_latch: op=%0d a=%0d b=%0d expected 0 25 17", alu_op, alu_a, alu_b); end
    tick();
    checks++; if (alu_start !== 0) begin errors++; $display("FAIL single_start_width: start=%b expected 0", alu_start); end
    for (int c = 3; c <= 4; c++) begin
      tick();
      checks++; if (resp_valid !== 0) begin errors++; $display("FAIL single_early cycle %0d: valid=%b expected 0", c, resp_valid); end
    end
    tick();
    checks++; if (resp_valid !== 4'b0001 || resp_result !== 16'd42 || resp_err !== 0) begin errors++; $display("FAIL single_resp: valid=%b result=%0d err=%b expected 0001 42 0", resp_valid, resp_result, resp_err); end
    req = 0; tick();
    checks++; if (busy !== 0 || resp_valid !== 0) begin errors++; $display("FAIL single_done: busy=%b valid=%b expected 0 0", busy, resp_valid); end
    ptr_m = 1;
  endtask

  task automatic test_all_four();
    int order[5] = '{0, 1, 2, 3, 0};
    logic [15:0] res[5] = '{16'd50, 16'd8, 16'hFFCE, 16'd50, 16'd50};
    int lat, starts; logic [3:0] rv; logic [15:0] rr; logic re; logic [1:0] gid;
    pulse_reset();
    set_op(0, 3'd2, 8'd10, 8'd5); set_op(1, 3'd2, 8'd4, 8'd2);
    set_op(2, 3'd2, 8'hF6, 8'd5); set_op(3, 3'd2, 8'hF6, 8'hFB);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      alu_delay = $urandom_range(1, 5);
      wait_resp(lat, rv, rr, re, gid, starts);
      checks++; if (gid !== 2'(order[k]) || rv !== 4'(1 << order[k])) begin errors++; $display("FAIL all4_grant %0d: gid=%0d valid=%b expected %0d", k, gid, rv, order[k]); end
      checks++; if (rr !== res[k] || re !== 0) begin errors++; $display("FAIL all4_result %0d: result=%h err=%b expected %h 0", k, rr, re, res[k]); end
      checks++; if (lat != alu_delay + 1 || starts != 1) begin errors++; $display("FAIL all4_latency %0d: lat=%0d starts=%0d expected %0d 1", k, lat, starts, alu_delay + 1); end
    end
    req = 0; ptr_m = 1;
  endtask

  task automatic test_pointer_wrap();
    logic [3:0] seq[3] = '{4'b0100, 4'b0101, 4'b0100};
    int want[3] = '{2, 0, 2};
    int lat, starts, exp; logic [3:0] rv; logic [15:0] rr; logic re; logic [1:0] gid;
    pulse_reset();
    for (int k = 0; k < 3; k++) begin
      rand_ops(); req = seq[k]; alu_delay = $urandom_range(1, 4);
      exp = ref_pick(req, ptr_m);
      wait_resp(lat, rv, rr, re, gid, starts);
      checks++; if (gid !== 2'(want[k]) || exp != want[k] || rv !== 4'(1 << want[k])) begin errors++; $display("FAIL wrap_grant %0d: gid=%0d valid=%b expected %0d", k, gid, rv, want[k]); end
      checks++; if (rr !== ref_of(want[k])) begin errors++; $display("FAIL wrap_result %0d: result=%h expected %h", k, rr, ref_of(want[k])); end
      ptr_m = (want[k] + 1) % 4;
    end
    req = 0;
  endtask

  task automatic test_timeout();
    int lat, starts, exp; logic [3:0] rv; logic [15:0] rr; logic re; logic [1:0] gid;
    rand_ops(); never_done = 1; req = 4'b0010;
    wait_resp(lat, rv, rr, re, gid, starts);
    checks++; if (lat != 64 || rv !== 4'b0010) begin errors++; $display("FAIL timeout_latency: lat=%0d valid=%b expected 64 0010", lat, rv); end
    checks++; if (re !== 1 || rr !== 0) begin errors++; $display("FAIL timeout_flag: err=%b result=%h expected 1 0000", re, rr); end
    ptr_m = 2; never_done = 0; rand_ops(); req = 4'b1001; alu_delay = 2;
    exp = ref_pick(req, ptr_m);
    wait_resp(lat, rv, rr, re, gid, starts);
    checks++; if (gid !== 2'(exp) || re !== 0 || rr !== ref_of(exp) || lat != 3) begin errors++; $display("FAIL timeout_recover: gid=%0d err=%b result=%h lat=%0d expected %0d 0 %h 3", gid, re, rr, lat, exp, ref_of(exp)); end
    ptr_m = (exp + 1) % 4; req = 0;
  endtask

  task automatic test_operand_hold();
    int lat, starts; logic [3:0] rv; logic [15:0] rr; logic re; logic [1:0] gid;
    set_op(0, 3'd1, 8'd50, 8'd8); alu_delay = 6; req = 4'b0001;
    tick(); tick(); tick();
    set_op(0, 3'd2, 8'd99, 8'd7);
    tick();
    checks++; if (alu_a !== 50 || alu_op !== 1 || alu_b !== 8) begin errors++; $display("FAIL hold_operands: op=%0d a=%0d b=%0d expected 1 50 8", alu_op, alu_a, alu_b); end
    wait_resp(lat, rv, rr, re, gid, starts);
    checks++; if (rv !== 4'b0001 || rr !== 16'd42) begin errors++; $display("FAIL hold_result: valid=%b result=%0d expected 0001 42", rv, rr); end
    req = 0; ptr_m = 1; stray_done = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (resp_valid !== 0 || busy !== 0) begin errors++; $display("FAIL stray_done %0d: valid=%b busy=%b expected 0 0", c, resp_valid, busy); end
    end
    stray_done = 0; tick();
    checks++; if (resp_result !== 16'd42) begin errors++; $display("FAIL stray_result: result=%h expected 002a", resp_result); end
  endtask

  task automatic test_async_reset();
    int lat, starts; logic [3:0] rv; logic [15:0] rr; logic re; logic [1:0] gid;
    rand_ops(); alu_delay = 2; req = 4'b0010;
    wait_resp(lat, rv, rr, re, gid, starts);
    checks++; if (gid !== 1) begin errors++; $display("FAIL areset_prep: gid=%0d expected 1", gid); end
    set_op(3, 3'd6, 8'h5A, 8'h3C); alu_delay = 20; req = 4'b1000;
    for (int c = 0; c < 5; c++) tick();
    checks++; if (busy !== 1 || grant_id !== 3) begin errors++; $display("FAIL areset_inflight: busy=%b gid=%0d expected 1 3", busy, grant_id); end
    #2 reset = 1; #1;
    checks++; if (resp_valid !== 0 || busy !== 0 || alu_start !== 0 || grant_id !== 0) begin errors++; $display("FAIL areset_ctrl: valid=%b busy=%b start=%b gid=%0d expected 0", resp_valid, busy, alu_start, grant_id); end
    checks++; if (alu_op !== 0 || alu_a !== 0 || alu_b !== 0 || resp_result !== 0 || resp_err !== 0) begin errors++; $display("FAIL areset_data: op=%0d a=%h b=%h result=%h err=%b expected 0", alu_op, alu_a, alu_b, resp_result, resp_err); end
    req = 0; tick(); tick(); reset = 0; ptr_m = 0;
    rand_ops(); alu_delay = 3; req = 4'b0110;
    wait_resp(lat, rv, rr, re, gid, starts);
    checks++; if (gid !== 2'(ref_pick(4'b0110, 0)) || rv !== 4'b0010 || rr !== ref_of(1) || lat != 4) begin errors++; $display("FAIL areset_after: gid=%0d valid=%b result=%h lat=%0d expected 1 0010 %h 4", gid, rv, rr, lat, ref_of(1)); end
    req = 0; ptr_m = 2;
  endtask

  task automatic test_random();
    int lat, starts, exp; logic [3:0] rv; logic [15:0] rr; logic re; logic [1:0] gid;
    for (int k = 0; k < 30; k++) begin
      rand_ops(); req = 4'($urandom_range(1, 15)); alu_delay = $urandom_range(1, 6);
      exp = ref_pick(req, ptr_m);
      wait_resp(lat, rv, rr, re, gid, starts);
      checks++; if (gid !== 2'(exp) || rv !== 4'(1 << exp)) begin errors++; $display("FAIL rand_grant %0d: gid=%0d valid=%b expected %0d", k, gid, rv, exp); end
      checks++; if (rr !== ref_of(exp) || re !== 0 || lat != alu_delay + 1) begin errors++; $display("FAIL rand_result %0d: result=%h err=%b lat=%0d expected %h 0 %0d", k, rr, re, lat, ref_of(exp), alu_delay + 1); end
      ptr_m = (exp + 1) % 4;
    end
    req = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_pointer_wrap();
    test_timeout();
    test_operand_hold();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
